// File: rtl/if_pdu2ctrl_tx_if.sv
// Handshake and line bundle between the PDU status source and the controller-link transmitter.
interface if_pdu2ctrl_tx_if;
  localparam int unsigned STATUS_W = 16;
  localparam int unsigned CNT_W    = 8;

  logic                send_in;
  logic [STATUS_W-1:0] status_in;
  logic                tx_out;
  logic                de_out;
  logic                busy_out;
  logic                drop_out;
  logic [CNT_W-1:0]    frame_cnt_out;

  modport master (
    output send_in, status_in,
    input  tx_out, de_out, busy_out, drop_out, frame_cnt_out
  );

  modport slave (
    input  send_in, status_in,
    output tx_out, de_out, busy_out, drop_out, frame_cnt_out
  );
endinterface

// File: rtl/if_pdu2ctrl_tx.sv
// Serialises the 16-bit PDU status word as a 4-byte 8N1 frame (A5, lo, hi, sum)
// on a half-duplex line, with a driver-enable guard interval ahead of the first start bit.
module if_pdu2ctrl_tx #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned GUARD_BITS = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  if_pdu2ctrl_tx_if.slave bus
);
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned GUARD_W = 4;
  localparam logic [7:0]         SYNC_BYTE    = 8'hA5;
  localparam logic [TIMER_W-1:0] BIT_RELOAD   = TIMER_W'(CLK_DIV - 1);
  localparam logic [GUARD_W-1:0] GUARD_RELOAD = GUARD_W'(GUARD_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [15:0]        status_q, status_d;
  logic [7:0]         chk_q, chk_d;
  logic               tx_q, tx_d;
  logic               de_q, de_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  logic               bit_end_c;
  logic [2:0]         next_bit_c;
  logic [7:0]         cur_byte_c;

  // Next-state and registered-output computation; tx_d always reflects the level of the state being entered.
  always_comb begin
    state_d     = state_q;
    timer_d     = bit_end_c_calc(timer_q) ? BIT_RELOAD : timer_q - TIMER_W'(1);
    guard_d     = guard_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    status_d    = status_q;
    chk_d       = chk_q;
    tx_d        = tx_q;
    de_d        = de_q;
    busy_d      = busy_q;
    drop_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    bit_end_c   = (timer_q == '0);
    next_bit_c  = bit_idx_q + 3'd1;

    case (byte_idx_q)
      2'd0:    cur_byte_c = SYNC_BYTE;
      2'd1:    cur_byte_c = status_q[7:0];
      2'd2:    cur_byte_c = status_q[15:8];
      default: cur_byte_c = chk_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        timer_d = BIT_RELOAD;
        if (bus.send_in) begin
          state_d    = ST_GUARD;
          status_d   = bus.status_in;
          chk_d      = SYNC_BYTE + bus.status_in[7:0] + bus.status_in[15:8];
          guard_d    = GUARD_RELOAD;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          tx_d       = 1'b1;
          de_d       = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_GUARD: begin
        if (bit_end_c) begin
          if (guard_q == '0) begin
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            guard_d = guard_q - GUARD_W'(1);
          end
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte_c[0];
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit_c;
            tx_d      = cur_byte_c[next_bit_c];
          end
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (byte_idx_q != 2'd3) begin
            state_d    = ST_START;
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
          end else begin
            state_d     = ST_IDLE;
            tx_d        = 1'b1;
            de_d        = 1'b0;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        de_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Strobes seen in any non-idle state, including the last stop-bit cycle, are rejected.
    if (bus.send_in && (state_q != ST_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  function automatic logic bit_end_c_calc(input logic [TIMER_W-1:0] t);
    return (t == '0);
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      timer_q     <= BIT_RELOAD;
      guard_q     <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      status_q    <= '0;
      chk_q       <= '0;
      tx_q        <= 1'b1;
      de_q        <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      guard_q     <= guard_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      status_q    <= status_d;
      chk_q       <= chk_d;
      tx_q        <= tx_d;
      de_q        <= de_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.tx_out        = tx_q;
  assign bus.de_out        = de_q;
  assign bus.busy_out      = busy_q;
  assign bus.drop_out      = drop_q;
  assign bus.frame_cnt_out = frame_cnt_q;
endmodule

// File: tb/tb_if_pdu2ctrl_tx.sv
// Scoreboard bench: stimulus queues hand-computed frame bytes, a line-decoder monitor pops and compares them.
module tb_if_pdu2ctrl_tx;
  localparam int D     = 4;
  localparam int G     = 1;
  localparam int FRAME = (G + 40) * D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  if_pdu2ctrl_tx_if bus();

  if_pdu2ctrl_tx #(.CLK_DIV(D), .GUARD_BITS(G)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  // Returns just after the accepting rising edge.
  task automatic send(input logic [15:0] s);
    @(negedge clk);
    bus.send_in   = 1'b1;
    bus.status_in = s;
    @(posedge clk);
    #1;
    bus.send_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_out) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic run_frame(input bit toggle, output int de_cyc, output int start_off);
    de_cyc    = 0;
    start_off = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (toggle) bus.status_in = 16'($urandom);
      if (bus.de_out) begin
        if (start_off < 0 && !bus.tx_out) start_off = de_cyc;
        de_cyc++;
      end else if (de_cyc > 0) begin
        break;
      end
    end
  endtask

  // Line decoder: samples every cycle of each character and pops the scoreboard per byte.
  initial begin : line_mon
    logic [7:0] b;
    logic [7:0] e;
    bit         ok;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rst_n && bus.de_out && !bus.tx_out) begin
        ok    = 1'b1;
        abort = 1'b0;
        b     = '0;
        for (int s = 1; s < D && !abort; s++) begin
          @(negedge clk);
          if (!rst_n || !bus.de_out) abort = 1'b1;
          else if (bus.tx_out) ok = 1'b0;
        end
        for (int k = 0; k < 8 && !abort; k++) begin
          for (int s = 0; s < D && !abort; s++) begin
            @(negedge clk);
            if (!rst_n || !bus.de_out) abort = 1'b1;
            else if (s == 0) b[k] = bus.tx_out;
            else if (bus.tx_out !== b[k]) ok = 1'b0;
          end
        end
        for (int s = 0; s < D && !abort; s++) begin
          @(negedge clk);
          if (!rst_n || !bus.de_out) abort = 1'b1;
          else if (!bus.tx_out) ok = 1'b0;
        end
        if (!abort) begin
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL char_shape byte=0x%0h actual=malformed required=start0_8bits_stop1_%0dcyc", b, D);
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", b);
          end else begin
            e = exp_q.pop_front();
            check("line_byte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  initial begin : stim
    int dc;
    int so;
    int de_seen;
    logic [15:0] s;
    logic [7:0]  c;
    bus.send_in   = 1'b0;
    bus.status_in = '0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",   32'(bus.tx_out), 32'd1);
    check("rst_de",   32'(bus.de_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_drop", 32'(bus.drop_out), 32'd0);
    check("rst_cnt",  32'(bus.frame_cnt_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0x1234
    push4(8'hA5, 8'h34, 8'h12, 8'hEB);
    send(16'h1234);
    check("busy_after_accept", 32'(bus.busy_out), 32'd1);
    run_frame(1'b0, dc, so);
    check("single_de_len", 32'(dc), 32'(FRAME));
    check("single_cnt", 32'(bus.frame_cnt_out), 32'd1);
    check("single_end_tx", 32'(bus.tx_out), 32'd1);
    check("single_end_busy", 32'(bus.busy_out), 32'd0);

    // Bit timing 0x00FF
    push4(8'hA5, 8'hFF, 8'h00, 8'hA4);
    send(16'h00FF);
    run_frame(1'b0, dc, so);
    check("timing_start_off", 32'(so), 32'd4);
    check("timing_de_len", 32'(dc), 32'd164);
    check("timing_cnt", 32'(bus.frame_cnt_out), 32'd2);

    // Drop during byte 2
    push4(8'hA5, 8'h34, 8'h12, 8'hEB);
    send(16'h1234);
    repeat (100) @(posedge clk);
    #1;
    bus.send_in   = 1'b1;
    bus.status_in = 16'hBEEF;
    @(posedge clk);
    #1;
    bus.send_in   = 1'b0;
    bus.status_in = 16'h0000;
    @(negedge clk);
    check("drop_pulse", 32'(bus.drop_out), 32'd1);
    check("drop_busy", 32'(bus.busy_out), 32'd1);
    @(negedge clk);
    check("drop_one_cycle", 32'(bus.drop_out), 32'd0);
    wait_idle("drop_frame");
    check("drop_cnt", 32'(bus.frame_cnt_out), 32'd3);
    de_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.de_out) de_seen++;
    end
    check("drop_no_second_frame", 32'(de_seen), 32'd0);

    // Strobe in final stop cycle is dropped; strobe in first idle cycle is accepted
    push4(8'hA5, 8'h11, 8'h22, 8'hD8);
    send(16'h2211);
    repeat (FRAME - 1) @(posedge clk);
    #1;
    bus.send_in   = 1'b1;
    bus.status_in = 16'h0102;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_end_busy", 32'(bus.busy_out), 32'd0);
    check("b2b_end_de", 32'(bus.de_out), 32'd0);
    check("b2b_stop_drop", 32'(bus.drop_out), 32'd1);
    check("b2b_cnt_a", 32'(bus.frame_cnt_out), 32'd4);
    push4(8'hA5, 8'h02, 8'h01, 8'hA8);
    @(posedge clk);
    #1;
    bus.send_in = 1'b0;
    run_frame(1'b0, dc, so);
    check("b2b_guard", 32'(so), 32'd4);
    check("b2b_de_len", 32'(dc), 32'(FRAME));
    check("b2b_cnt_b", 32'(bus.frame_cnt_out), 32'd5);

    // Latched data unaffected by status toggling
    push4(8'hA5, 8'h5A, 8'hA5, 8'hA4);
    send(16'hA55A);
    run_frame(1'b1, dc, so);
    check("stable_cnt", 32'(bus.frame_cnt_out), 32'd6);

    // Reset during byte 1 data
    exp_q.push_back(8'hA5);
    send(16'h5678);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(bus.tx_out), 32'd1);
    check("midrst_de", 32'(bus.de_out), 32'd0);
    check("midrst_busy", 32'(bus.busy_out), 32'd0);
    check("midrst_cnt", 32'(bus.frame_cnt_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push4(8'hA5, 8'h34, 8'h12, 8'hEB);
    send(16'h1234);
    run_frame(1'b0, dc, so);
    check("postrst_de_len", 32'(dc), 32'(FRAME));
    check("postrst_cnt", 32'(bus.frame_cnt_out), 32'd1);

    // Counter wrap
    for (int i = 0; i < 255; i++) begin
      s = 16'(i * 257) ^ 16'h3C5A;
      c = 8'hA5 + s[7:0] + s[15:8];
      push4(8'hA5, s[7:0], s[15:8], c);
      send(s);
      wait_idle("wrap_frame");
      if (i == 253) check("wrap_cnt_255", 32'(bus.frame_cnt_out), 32'd255);
    end
    check("wrap_cnt_0", 32'(bus.frame_cnt_out), 32'd0);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
